// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state type and sizing helper for the bit-serial arithmetic blocks
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - full-adder cell with combinational sum and registered carry
module serial_fa_cell (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic en,
    input  logic load,
    input  logic carry_in,
    output logic sum,
    output logic cout
);

    logic carry;

    assign sum  = a ^ b ^ carry;
    assign cout = (a & b) | (a & carry) | (b & carry);

    // A load takes priority so that a new operation always starts from carry_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry <= 1'b0;
        end else if (load) begin
            carry <= carry_in;
        end else if (en) begin
            carry <= cout;
        end
    end

endmodule

// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial N-bit adder, LSB first; SERIAL_SUB_EN adds the sub port (A-B)
module serial_adder_n
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_vld,
    input  logic             a_bit,
    input  logic             b_bit,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);

    localparam int CW = cnt_w(WIDTH);

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           beat;
    logic           last;
    logic           b_eff;
    logic           carry_in;
    logic           s;
    logic           cout;

    assign accept = start && (state != RUN);
    assign beat   = in_vld && (state == RUN);
    assign last   = beat && (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_EN
    logic sub_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub;
        end
    end

    // Subtraction is A + ~B + 1; carry_in loads alongside sub_q on accept.
    assign carry_in = sub;
    assign b_eff    = b_bit ^ sub_q;
`else
    assign carry_in = 1'b0;
    assign b_eff    = b_bit;
`endif

    serial_fa_cell u_fa (
        .clk      (clk),
        .rst      (rst),
        .a        (a_bit),
        .b        (b_eff),
        .en       (beat),
        .load     (accept),
        .carry_in (carry_in),
        .sum      (s),
        .cout     (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            cnt    <= '0;
            result <= '0;
        end else if (beat) begin
            cnt                 <= cnt + 1'b1;
            result[WIDTH-1:0]   <= {s, result[WIDTH-1:1]};
            if (last) begin
                result[WIDTH] <= cout;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_n.sv
// tb/tb_serial_adder_n.sv - directed-vector bench for serial_adder_n (WIDTH=4)
module tb_serial_adder_n;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_vld;
    logic       a_bit;
    logic       b_bit;
`ifdef SERIAL_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [4:0] result;

    int nvec;
    int nfail;

    serial_adder_n #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in_vld (in_vld),
        .a_bit  (a_bit),
        .b_bit  (b_bit),
`ifdef SERIAL_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; returns cycles from the start cycle to the done cycle.
    // Leaves the bench sitting in the done cycle. restart_at re-pulses start with that beat.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         input int stall_at, input int stall_len, input int restart_at,
                         output int lat, output logic [4:0] res);
        int bi;
        int stalled;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        bi = 0;
        stalled = 0;
        while (!done && lat < 40) begin
            start = 1'b0;
            if (bi == stall_at && stalled < stall_len) begin
                in_vld = 1'b0;
                stalled++;
            end else if (bi < 4) begin
                in_vld = 1'b1;
                a_bit  = a[bi];
                b_bit  = b[bi];
                if (bi == restart_at) start = 1'b1;
                bi++;
            end else begin
                in_vld = 1'b0;
            end
            tick();
            lat++;
        end
        start  = 1'b0;
        in_vld = 1'b0;
        res    = result;
        nvec++;
        if (done !== 1'b1) begin
            nfail++;
            $display("FAIL op_timeout: done=%b after %0d cycles, required 1", done, lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_vld = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
`ifdef SERIAL_SUB_EN
        sub = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        tick();
        nvec++;
        if ({busy, done, result} !== 7'b0) begin
            nfail++;
            $display("FAIL reset_state: busy=%b done=%b result=%b, required 0 0 00000", busy, done, result);
        end
        // in_vld outside RUN must not disturb anything
        in_vld = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
        tick();
        in_vld = 1'b0;
        nvec++;
        if ({busy, done, result} !== 7'b0) begin
            nfail++;
            $display("FAIL idle_in_vld: busy=%b done=%b result=%b, required 0 0 00000", busy, done, result);
        end
    endtask

    task automatic test_add();
        int lat;
        logic [4:0] res;
        do_op(4'd5, 4'd3, -1, 0, -1, lat, res);
        nvec++;
        if (res !== 5'b01000) begin nfail++; $display("FAIL add_5_3: result=%b, required 01000", res); end
        nvec++;
        if (lat !== 5) begin nfail++; $display("FAIL add_latency: got %0d cycles, required 5", lat); end
        tick();
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL done_pulse: done=%b busy=%b after pulse, required 0 0", done, busy);
        end
        nvec++;
        if (result !== 5'b01000) begin nfail++; $display("FAIL result_hold: result=%b, required 01000", result); end
    endtask

    task automatic test_stall();
        int lat;
        logic [4:0] res;
        do_op(4'd15, 4'd15, 2, 3, -1, lat, res);
        nvec++;
        if (res !== 5'b11110) begin nfail++; $display("FAIL stall_15_15: result=%b, required 11110", res); end
        nvec++;
        if (lat !== 8) begin nfail++; $display("FAIL stall_latency: got %0d cycles, required 8", lat); end
        tick();
    endtask

    task automatic test_start_in_run();
        int lat;
        logic [4:0] res;
        do_op(4'd0, 4'd1, -1, 0, 2, lat, res);
        nvec++;
        if (res !== 5'b00001) begin nfail++; $display("FAIL restart_ignored: result=%b, required 00001", res); end
        nvec++;
        if (lat !== 5) begin nfail++; $display("FAIL restart_latency: got %0d cycles, required 5", lat); end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [4:0] res;
        start = 1'b1; tick(); start = 1'b0;
        in_vld = 1'b1; a_bit = 1'b1; b_bit = 1'b1; tick();
        a_bit = 1'b1; b_bit = 1'b0; tick();
        in_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (busy !== 1'b0 || result !== 5'b0) begin
            nfail++;
            $display("FAIL async_reset: busy=%b result=%b, required 0 00000", busy, result);
        end
        tick();
        rst = 1'b0;
        tick();
        do_op(4'd9, 4'd6, -1, 0, -1, lat, res);
        nvec++;
        if (res !== 5'b01111) begin nfail++; $display("FAIL after_reset_9_6: result=%b, required 01111", res); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [4:0] res;
        logic [3:0] a2;
        logic [3:0] b2;
        do_op(4'd6, 4'd7, -1, 0, -1, lat, res);
        nvec++;
        if (res !== 5'b01101) begin nfail++; $display("FAIL b2b_first: result=%b, required 01101", res); end
        // start and a junk beat in the DONE cycle: start accepted, beat dropped
        start = 1'b1; in_vld = 1'b1; a_bit = 1'b1; b_bit = 1'b1;
        tick();
        start = 1'b0;
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== 5'b0) begin
            nfail++;
            $display("FAIL b2b_accept: busy=%b done=%b result=%b, required 1 0 00000", busy, done, result);
        end
        a2 = 4'd10;
        b2 = 4'd12;
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1; a_bit = a2[i]; b_bit = b2[i];
            tick();
        end
        in_vld = 1'b0;
        nvec++;
        if (done !== 1'b1 || result !== 5'b10110) begin
            nfail++;
            $display("FAIL b2b_second: done=%b result=%b, required 1 10110", done, result);
        end
        tick();
    endtask

`ifdef SERIAL_SUB_EN
    task automatic test_sub();
        int lat;
        logic [4:0] res;
        sub = 1'b1;
        do_op(4'd3, 4'd5, -1, 0, -1, lat, res);
        nvec++;
        if (res !== 5'b01110) begin nfail++; $display("FAIL sub_3_5: result=%b, required 01110", res); end
        tick();
        do_op(4'd7, 4'd2, -1, 0, -1, lat, res);
        nvec++;
        if (res !== 5'b10101) begin nfail++; $display("FAIL sub_7_2: result=%b, required 10101", res); end
        tick();
        sub = 1'b0;
        do_op(4'd7, 4'd2, -1, 0, -1, lat, res);
        nvec++;
        if (res !== 5'b01001) begin nfail++; $display("FAIL add_after_sub: result=%b, required 01001", res); end
        tick();
    endtask
`endif

    initial begin
        nvec  = 0;
        nfail = 0;
        test_reset();
        test_add();
        test_stall();
        test_start_in_run();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
